// File: rtl/contador_sweep_ctrl.sv
// contador_sweep_ctrl
//
// Drives an external N-bit up/down counter through a programmable triangle
// sweep. The counter is loaded with lo, counted up to hi, counted back down
// to lo, and the up+down pattern repeats num_sweeps times.
//
// Counter control encoding:
//   enable=1 load=1 -> load ref
//   enable=1 load=0 -> hold
//   enable=0        -> count down when dec=1, otherwise count up
//
// Ports
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   start            : run request, sampled only in IDLE
//   abort            : cancel request, sampled in every non-IDLE state
//   lo_value         : sweep floor, latched on an accepted start
//   hi_value         : sweep peak, latched on an accepted start
//   num_sweeps       : number of up+down sweeps, latched on an accepted start
//   cnt_value        : counter value read back
//   cnt_threshold    : counter flag, high when cnt_value > cnt_ref_value
//   cnt_enable       : counter enable (combinational)
//   cnt_dec          : counter direction (combinational)
//   cnt_load         : counter load strobe (combinational)
//   cnt_ref_value    : counter load / compare value (combinational)
//   busy             : high in every state other than IDLE
//   done             : one-cycle pulse on successful completion
//   error            : one-cycle pulse on a rejected start or on overrun
//   direction        : 1 while descending, else 0
//   sweep_count      : sweeps completed in the current run
//
// Handshake: start is a level request. It is accepted on any IDLE cycle and
// ignored while busy. abort is a level request honoured on any non-IDLE
// cycle and takes priority over every other transition.
module contador_sweep_ctrl #(
  parameter int N = 32,
  parameter int S = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [N-1:0] lo_value,
  input  logic [N-1:0] hi_value,
  input  logic [S-1:0] num_sweeps,
  input  logic [N-1:0] cnt_value,
  input  logic         cnt_threshold,
  output logic         cnt_enable,
  output logic         cnt_dec,
  output logic         cnt_load,
  output logic [N-1:0] cnt_ref_value,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic         direction,
  output logic [S-1:0] sweep_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    UP   = 3'd2,
    DOWN = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t       state;
  logic [N-1:0] lo_r;
  logic [N-1:0] hi_r;
  logic [S-1:0] ns_r;

  logic         at_hi;
  logic         at_lo;
  logic         overrun;
  logic         start_ok;
  logic [S-1:0] sweep_next;

  assign at_hi      = (cnt_value == hi_r);
  assign at_lo      = (cnt_value == lo_r);
  assign start_ok   = (lo_value < hi_value) && (num_sweeps != '0);
  assign sweep_next = sweep_count + 1'b1;

  // While descending the threshold flag is legitimately high (counter above
  // lo), so the overrun guard only means something on the way up.
  assign overrun = (state == UP) && cnt_threshold && !at_hi;

  // Counter controls. The reference value follows the state regardless of
  // abort; abort (and an overrun) only suppresses motion and loading.
  always_comb begin
    cnt_enable    = 1'b1;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;
    cnt_ref_value = hi_r;
    case (state)
      LOAD:    cnt_ref_value = lo_r;
      DOWN:    cnt_ref_value = lo_r;
      default: cnt_ref_value = hi_r;
    endcase
    if (!abort) begin
      case (state)
        LOAD: cnt_load = 1'b1;
        UP: begin
          if (!at_hi && !overrun) begin
            cnt_enable = 1'b0;
          end
        end
        DOWN: begin
          if (!at_lo) begin
            cnt_enable = 1'b0;
            cnt_dec    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM with registered status outputs. busy/direction/done are computed
  // from the next state so they line up with the state they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      lo_r        <= '0;
      hi_r        <= '0;
      ns_r        <= '0;
      sweep_count <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      direction   <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          if (start_ok) begin
            lo_r        <= lo_value;
            hi_r        <= hi_value;
            ns_r        <= num_sweeps;
            sweep_count <= '0;
            state       <= LOAD;
            busy        <= 1'b1;
          end else begin
            error <= 1'b1;
          end
        end
      end else if (abort) begin
        state     <= IDLE;
        busy      <= 1'b0;
        direction <= 1'b0;
      end else begin
        case (state)
          LOAD: state <= UP;
          UP: begin
            if (overrun) begin
              error <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end else if (at_hi) begin
              state     <= DOWN;
              direction <= 1'b1;
            end
          end
          DOWN: begin
            if (at_lo) begin
              sweep_count <= sweep_next;
              direction   <= 1'b0;
              if (sweep_next == ns_r) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= UP;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_contador_sweep_ctrl.sv
module tb_contador_sweep_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] lo_value = '0;
  logic [31:0] hi_value = '0;
  logic [7:0]  num_sweeps = '0;
  logic [31:0] cnt_value;
  logic        cnt_threshold;
  logic        cnt_enable;
  logic        cnt_dec;
  logic        cnt_load;
  logic [31:0] cnt_ref_value;
  logic        busy;
  logic        done;
  logic        error;
  logic        direction;
  logic [7:0]  sweep_count;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // clock / reset block
  always #5 clock = ~clock;

  contador_sweep_ctrl #(.N(32), .S(8)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .lo_value(lo_value), .hi_value(hi_value), .num_sweeps(num_sweeps),
    .cnt_value(cnt_value), .cnt_threshold(cnt_threshold),
    .cnt_enable(cnt_enable), .cnt_dec(cnt_dec), .cnt_load(cnt_load),
    .cnt_ref_value(cnt_ref_value), .busy(busy), .done(done), .error(error),
    .direction(direction), .sweep_count(sweep_count)
  );

  // Behavioural model of the external up/down counter, with an override
  // used to inject an out-of-range value.
  logic [31:0] cnt_q;
  logic        force_cnt = 1'b0;
  logic [31:0] force_val = '0;
  always @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else if (cnt_enable) begin
      if (cnt_load) cnt_q <= cnt_ref_value;
    end else if (cnt_dec) cnt_q <= cnt_q - 1;
    else cnt_q <= cnt_q + 1;
  end
  assign cnt_value     = force_cnt ? force_val : cnt_q;
  assign cnt_threshold = (cnt_value > cnt_ref_value);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic begin_run(input logic [31:0] lo, input logic [31:0] hi, input logic [7:0] ns);
    lo_value = lo; hi_value = hi; num_sweeps = ns; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_dir"}, direction, 0);
    check({tag, "_sc"}, sweep_count, 0);
    check({tag, "_en"}, cnt_enable, 1);
    check({tag, "_load"}, cnt_load, 0);
    check({tag, "_dec"}, cnt_dec, 0);
    check({tag, "_ref"}, cnt_ref_value, 0);
  endtask

  initial begin
    int done_at;
    int toggles;
    logic prev_dir;
    logic [7:0] prev_sc;

    step(); step();
    reset = 1'b0;
    check_reset_values("rst");
    check("rst_cnt", cnt_value, 0);

    // Single sweep lo=2 hi=5
    begin_run(2, 5, 1);
    check("s1_t1_busy", busy, 1);
    check("s1_t1_load", cnt_load, 1);
    check("s1_t1_ref", cnt_ref_value, 2);
    exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4); exp_q.push_back(5);
    exp_q.push_back(5); exp_q.push_back(4); exp_q.push_back(3); exp_q.push_back(2);
    for (int i = 2; i <= 9; i++) begin
      step();
      check("s1_cnt", cnt_value, exp_q.pop_front());
      check("s1_dir", direction, 32'(i >= 6));
      check("s1_done_low", done, 0);
    end
    step();
    check("s1_t10_done", done, 1);
    check("s1_t10_sc", sweep_count, 1);
    step();
    check("s1_t11_busy", busy, 0);
    check("s1_t11_done", done, 0);

    // Three sweeps lo=0 hi=3, done expected at t0+26
    begin_run(0, 3, 3);
    check("s3_t1_sc", sweep_count, 0);
    prev_dir = direction;
    prev_sc = sweep_count;
    toggles = 0;
    done_at = 0;
    for (int cyc = 2; cyc <= 60; cyc++) begin
      step();
      if (direction != prev_dir) toggles++;
      prev_dir = direction;
      if (sweep_count != prev_sc) begin
        check("s3_sc_step", sweep_count, 32'(prev_sc) + 1);
        prev_sc = sweep_count;
      end
      if (done) begin
        done_at = cyc;
        break;
      end
    end
    check("s3_done_at", done_at, 26);
    check("s3_toggles", toggles, 6);
    check("s3_sc_final", sweep_count, 3);
    step();
    check("s3_idle_sc", sweep_count, 3);

    // Rejected starts: lo==hi, then num_sweeps==0
    begin_run(7, 7, 1);
    check("rej1_error", error, 1);
    check("rej1_busy", busy, 0);
    check("rej1_load", cnt_load, 0);
    check("rej1_ref", cnt_ref_value, 3);
    step();
    check("rej1_error_clr", error, 0);
    check("rej1_cnt", cnt_value, 0);
    begin_run(1, 4, 0);
    check("rej2_error", error, 1);
    check("rej2_busy", busy, 0);
    check("rej2_ref", cnt_ref_value, 3);
    step();
    check("rej2_error_clr", error, 0);
    check("rej2_cnt", cnt_value, 0);

    // Abort in UP at cnt_value=6
    begin_run(0, 10, 2);
    for (int i = 0; i < 30; i++) begin
      step();
      if (cnt_value == 6) break;
    end
    check("ab_reach6", cnt_value, 6);
    abort = 1'b1;
    #1;
    check("ab_hold_en", cnt_enable, 1);
    check("ab_hold_load", cnt_load, 0);
    check("ab_busy_before", busy, 1);
    step();
    abort = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_done", done, 0);
    check("ab_sc", sweep_count, 0);
    check("ab_cnt", cnt_value, 6);
    step();
    check("ab_cnt_still", cnt_value, 6);
    check("ab_done2", done, 0);

    // Overrun: counter reads 9 while climbing to 5
    begin_run(0, 5, 1);
    step(); step();
    force_cnt = 1'b1;
    force_val = 9;
    #1;
    check("ov_hold_en", cnt_enable, 1);
    step();
    force_cnt = 1'b0;
    check("ov_error", error, 1);
    check("ov_busy", busy, 0);
    check("ov_done", done, 0);
    step();
    check("ov_error_clr", error, 0);
    check("ov_done2", done, 0);

    // Reset mid-DOWN, then a clean run
    begin_run(2, 5, 1);
    for (int i = 0; i < 6; i++) step();
    check("rd_dir", direction, 1);
    check("rd_cnt", cnt_value, 4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_values("rd");
    check("rd_cnt_rst", cnt_value, 0);
    begin_run(1, 2, 1);
    done_at = 0;
    for (int cyc = 2; cyc <= 30; cyc++) begin
      step();
      if (done) begin
        done_at = cyc;
        break;
      end
    end
    check("rd_rerun_done_at", done_at, 6);
    check("rd_rerun_sc", sweep_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
